pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline; sits beside the forwarding logic.

---
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Covers the hazards the
// forwarding network cannot: load-use, multi-cycle MUL/DIV occupying EX,
// data-memory wait and taken-branch redirect. Also keeps saturating
// stall and flush counters.
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             IDEX_MemRead_i,
    input  logic             IDEX_mdu_i,
    input  logic             EXE_branch_taken_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             IFID_write_o,
    output logic             IDEX_write_o,
    output logic             EXMEM_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic             EXMEM_flush_o,
    output logic             MEMWB_flush_o,
    output logic             state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    // A one-cycle MUL/DIV never needs to hold EX, so the MDU path is compiled out.
    localparam bit         MDU_EN     = (MDU_LAT >= 2);
    // The trigger cycle is itself the first stall cycle, hence LAT-2 remaining.
    localparam logic [3:0] MDU_RELOAD = (MDU_LAT >= 2) ? 4'(MDU_LAT - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;
    logic       load_use;
    logic       flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign load_use = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                      ((ID_rs1_used_i && (ID_rs1_i == IDEX_rd_i)) ||
                       (ID_rs2_used_i && (ID_rs2_i == IDEX_rd_i)));

    assign state_o = (state_q == MDU);

    // Hazard priority resolution: MEM freeze > MDU stall > branch flush > load-use.
    always_comb begin
        pc_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IDEX_write_o  = 1'b1;
        EXMEM_write_o = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        EXMEM_flush_o = 1'b0;
        MEMWB_flush_o = 1'b0;
        state_d       = state_q;
        mdu_cnt_d     = mdu_cnt_q;
        flush_inc     = 1'b0;

        if (rst_i) begin
            pc_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_write_o  = 1'b0;
            EXMEM_write_o = 1'b0;
            IFID_flush_o  = 1'b1;
            IDEX_flush_o  = 1'b1;
            EXMEM_flush_o = 1'b1;
            MEMWB_flush_o = 1'b1;
        end else if (!dmem_ready_i) begin
            // Whole front end freezes; only a bubble drains into WB.
            pc_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_write_o  = 1'b0;
            EXMEM_write_o = 1'b0;
            MEMWB_flush_o = 1'b1;
        end else if (state_q == MDU) begin
            if (mdu_cnt_q != 4'd0) begin
                pc_write_o    = 1'b0;
                IFID_write_o  = 1'b0;
                IDEX_write_o  = 1'b0;
                EXMEM_flush_o = 1'b1;
                mdu_cnt_d     = mdu_cnt_q - 4'd1;
            end else begin
                // Release cycle: result leaves EX with default enables.
                state_d = RUN;
            end
        end else if (MDU_EN && IDEX_mdu_i) begin
            pc_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_write_o  = 1'b0;
            EXMEM_flush_o = 1'b1;
            mdu_cnt_d     = MDU_RELOAD;
            state_d       = MDU;
        end else if (EXE_branch_taken_i) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; any
            // load-use seen by the ID instruction is therefore irrelevant.
            IFID_flush_o = 1'b1;
            IDEX_flush_o = 1'b1;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            pc_write_o   = 1'b0;
            IFID_write_o = 1'b0;
            IDEX_flush_o = 1'b1;
        end
    end

    // Sequencer state and MDU countdown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mdu_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o) stall_cnt_o <= sat_inc(stall_cnt_o);
            if (flush_inc)   flush_cnt_o <= sat_inc(flush_cnt_o);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
// A (MDU_LAT=4, CNT_W=16) and B (MDU_LAT=1, CNT_W=4). A behavioural model
// is checked every cycle; literal expectations pin key points.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, u1, u2, memrd, mdu, br, rdy;
    logic [4:0] rs1, rs2, rd;

    logic        a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_exf, a_mwf, a_st;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_exf, b_mwf, b_st;
    logic [3:0]  b_scnt, b_fcnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .ID_rs1_i(rs1), .ID_rs2_i(rs2),
        .ID_rs1_used_i(u1), .ID_rs2_used_i(u2), .IDEX_rd_i(rd),
        .IDEX_MemRead_i(memrd), .IDEX_mdu_i(mdu), .EXE_branch_taken_i(br),
        .dmem_ready_i(rdy), .pc_write_o(a_pc), .IFID_write_o(a_ifw),
        .IDEX_write_o(a_idw), .EXMEM_write_o(a_exw), .IFID_flush_o(a_iff),
        .IDEX_flush_o(a_idf), .EXMEM_flush_o(a_exf), .MEMWB_flush_o(a_mwf),
        .state_o(a_st), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    pipeline_hazard_ctrl #(.MDU_LAT(1), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .ID_rs1_i(rs1), .ID_rs2_i(rs2),
        .ID_rs1_used_i(u1), .ID_rs2_used_i(u2), .IDEX_rd_i(rd),
        .IDEX_MemRead_i(memrd), .IDEX_mdu_i(mdu), .EXE_branch_taken_i(br),
        .dmem_ready_i(rdy), .pc_write_o(b_pc), .IFID_write_o(b_ifw),
        .IDEX_write_o(b_idw), .EXMEM_write_o(b_exw), .IFID_flush_o(b_iff),
        .IDEX_flush_o(b_idf), .EXMEM_flush_o(b_exf), .MEMWB_flush_o(b_mwf),
        .state_o(b_st), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output pattern order: pc, IFID_w, IDEX_w, EXMEM_w, IFID_f, IDEX_f, EXMEM_f, MEMWB_f
    localparam logic [7:0] O_DEF  = 8'b1111_0000;
    localparam logic [7:0] O_RST  = 8'b0000_1111;
    localparam logic [7:0] O_FRZ  = 8'b0000_0001;
    localparam logic [7:0] O_MDU  = 8'b0001_0010;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_LU   = 8'b0011_0100;

    int lat[2]  = '{4, 1};
    int wmax[2] = '{65535, 15};
    bit m_busy[2] = '{1'b0, 1'b0};
    int m_left[2] = '{0, 0};
    int m_scnt[2] = '{0, 0};
    int m_fcnt[2] = '{0, 0};

    // Returns expected {outputs, state} for the current inputs and advances the model.
    task automatic model_step(input int k, output logic [8:0] e);
        logic [7:0] o;
        bit lu, st, is_br;
        st = m_busy[k];
        is_br = 1'b0;
        lu = memrd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst) begin
            o = O_RST;
        end else if (!rdy) begin
            o = O_FRZ;
        end else if (m_busy[k] && m_left[k] > 0) begin
            o = O_MDU;
            m_left[k]--;
        end else if (m_busy[k]) begin
            o = O_DEF;
            m_busy[k] = 1'b0;
        end else if (mdu && lat[k] >= 2) begin
            o = O_MDU;
            m_busy[k] = 1'b1;
            m_left[k] = lat[k] - 2;
        end else if (br) begin
            o = O_BR;
            is_br = 1'b1;
        end else if (lu) begin
            o = O_LU;
        end else begin
            o = O_DEF;
        end
        if (rst) begin
            m_busy[k] = 1'b0; m_left[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end else begin
            if (!o[7] && m_scnt[k] < wmax[k]) m_scnt[k]++;
            if (is_br && m_fcnt[k] < wmax[k]) m_fcnt[k]++;
        end
        e = {o, st};
    endtask

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (chk_en) begin
            chk("a_stall_cnt", 32'(a_scnt), 32'(m_scnt[0]));
            chk("a_flush_cnt", 32'(a_fcnt), 32'(m_fcnt[0]));
            chk("b_stall_cnt", 32'(b_scnt), 32'(m_scnt[1]));
            chk("b_flush_cnt", 32'(b_fcnt), 32'(m_fcnt[1]));
            model_step(0, e);
            chk("a_outputs", 32'({a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_exf, a_mwf, a_st}), 32'(e));
            model_step(1, e);
            chk("b_outputs", 32'({b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_exf, b_mwf, b_st}), 32'(e));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rst = 1'b0; u1 = 1'b0; u2 = 1'b0; memrd = 1'b0; mdu = 1'b0; br = 1'b0; rdy = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset held two cycles
        idle(); rst = 1'b1;
        #1;
        chk("rst_pc_write", 32'(a_pc), 32'd0);
        chk("rst_idex_write", 32'(a_idw), 32'd0);
        chk("rst_ifid_flush", 32'(a_iff), 32'd1);
        chk("rst_memwb_flush", 32'(a_mwf), 32'd1);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("run_stall_cnt0", 32'(a_scnt), 32'd0);
        chk("run_flush_cnt0", 32'(a_fcnt), 32'd0);
        chk("run_writes", 32'({a_pc, a_ifw, a_idw, a_exw}), 32'hF);
        tick();

        // Load-use via rs2
        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1;
        #1;
        chk("lu_pc_write", 32'(a_pc), 32'd0);
        chk("lu_ifid_write", 32'(a_ifw), 32'd0);
        chk("lu_idex_flush", 32'(a_idf), 32'd1);
        tick();
        idle(); tick();
        chk("lu_stall_cnt", 32'(a_scnt), 32'd1);
        memrd = 1'b1; rd = 5'd0; rs2 = 5'd0; u2 = 1'b1;
        #1; chk("lu_rd0_pc_write", 32'(a_pc), 32'd1);
        tick();
        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b0;
        #1; chk("lu_unused_pc_write", 32'(a_pc), 32'd1);
        tick();
        idle(); memrd = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1;
        #1; chk("lu_rs1_pc_write", 32'(a_pc), 32'd0);
        tick();
        idle(); tick();

        // MDU stall of MDU_LAT-1 = 3 cycles
        do_reset();
        mdu = 1'b1;
        #1;
        chk("mdu_t0_state", 32'(a_st), 32'd0);
        chk("mdu_t0_pc", 32'(a_pc), 32'd0);
        chk("mdu_t0_exmem_flush", 32'(a_exf), 32'd1);
        chk("mdu_lat1_no_stall", 32'(b_pc), 32'd1);
        tick();
        chk("mdu_t1_state", 32'(a_st), 32'd1);
        chk("mdu_t1_pc", 32'(a_pc), 32'd0);
        tick();
        chk("mdu_t2_pc", 32'(a_pc), 32'd0);
        tick();
        mdu = 1'b0;
        #1;
        chk("mdu_rel_state", 32'(a_st), 32'd1);
        chk("mdu_rel_pc", 32'(a_pc), 32'd1);
        chk("mdu_rel_exmem_flush", 32'(a_exf), 32'd0);
        tick();
        chk("mdu_done_state", 32'(a_st), 32'd0);
        chk("mdu_stall_cnt", 32'(a_scnt), 32'd3);

        // Back-to-back MDU: re-trigger on the RUN cycle after release
        mdu = 1'b1;
        repeat (4) tick();
        chk("b2b_state", 32'(a_st), 32'd0);
        chk("b2b_pc", 32'(a_pc), 32'd0);
        repeat (4) tick();
        idle(); repeat (2) tick();

        // Branch + load-use in the same cycle
        do_reset();
        br = 1'b1; memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
        #1;
        chk("br_ifid_flush", 32'(a_iff), 32'd1);
        chk("br_idex_flush", 32'(a_idf), 32'd1);
        chk("br_pc_write", 32'(a_pc), 32'd1);
        tick();
        idle(); #1;
        chk("br_flush_cnt", 32'(a_fcnt), 32'd1);
        chk("br_stall_cnt", 32'(a_scnt), 32'd0);
        // Freeze outranks a branch: nothing counted as a flush
        br = 1'b1; rdy = 1'b0;
        tick();
        idle(); #1;
        chk("frz_br_flush_cnt", 32'(a_fcnt), 32'd1);
        tick();

        // MEM freeze while MDU has one stall cycle left
        mdu = 1'b1; tick();
        mdu = 1'b0; tick();
        rdy = 1'b0;
        #1;
        chk("frz_memwb_flush", 32'(a_mwf), 32'd1);
        chk("frz_exmem_write", 32'(a_exw), 32'd0);
        chk("frz_exmem_flush", 32'(a_exf), 32'd0);
        chk("frz_idex_flush", 32'(a_idf), 32'd0);
        tick();
        chk("frz2_state", 32'(a_st), 32'd1);
        tick();
        rdy = 1'b1;
        #1;
        chk("frz_after_pc", 32'(a_pc), 32'd0);
        chk("frz_after_exmem_flush", 32'(a_exf), 32'd1);
        tick();
        chk("frz_rel_pc", 32'(a_pc), 32'd1);
        chk("frz_rel_state", 32'(a_st), 32'd1);
        tick();
        chk("frz_done_state", 32'(a_st), 32'd0);
        tick();

        // Counter saturation
        do_reset();
        rdy = 1'b0;
        repeat (20) tick();
        chk("sat_b_stall", 32'(b_scnt), 32'd15);
        chk("sat_a_stall", 32'(a_scnt), 32'd20);
        do_reset();
        br = 1'b1;
        repeat (20) tick();
        chk("sat_b_flush", 32'(b_fcnt), 32'd15);
        chk("sat_a_flush", 32'(a_fcnt), 32'd20);

        // Reset in the middle of an MDU stall abandons it
        idle(); mdu = 1'b1; tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk("rst_mid_mdu_state", 32'(a_st), 32'd0);
        chk("rst_mid_mdu_pc", 32'(a_pc), 32'd1);
        repeat (3) tick();

        chk_en = 1'b0;
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
